// File: rtl/i2c_master_if.sv
// Host-side request/response bundle for the single-byte I2C master.
interface i2c_master_if;
    logic       start;
    logic       write;
    logic [6:0] address;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       ready;
    logic       error;

    modport master (
        input  start, write, address, write_data,
        output read_data, ready, error
    );

    modport slave (
        output start, write, address, write_data,
        input  read_data, ready, error
    );
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C master: one START/address/data/STOP transaction per accepted request.
// Each bus bit is four quarter-ticks; sda is open-drain, scl is push-pull.
module i2c_master #(
    parameter int QUARTER = 4
) (
    input  logic         clock,
    input  logic         reset,
    i2c_master_if.master host,
    output logic         scl,
    inout  wire          sda
);
    // state | meaning
    // IDLE  | bus idle, ready for a request
    // START | sda falls while scl stays high
    // ADDR  | shift out {address, ~write}
    // AACK  | sample slave address ACK
    // WDATA | shift out write byte
    // WACK  | sample slave data ACK
    // RDATA | shift in read byte
    // RNACK | master NACKs last byte, commit read_data
    // STOP  | sda rises while scl high
    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP
    } state_t;

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QUARTER - 1);

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          ack_q, ack_d;
    logic          error_q, error_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          sda_low;
    logic          sda_in;
    logic          tick;
    logic          sample;
    logic          slot_end;

    assign sda_in         = sda;
    assign sda            = sda_low ? 1'b0 : 1'bz;
    assign host.ready     = (state_q == IDLE);
    assign host.error     = error_q;
    assign host.read_data = rdata_q;

    always_comb begin
        tick     = (qcnt_q == QMAX);
        sample   = tick && (phase_q == 2'd2);
        slot_end = tick && (phase_q == 2'd3);

        state_d = state_q;
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        write_d = write_q;
        ack_d   = ack_q;
        error_d = error_q;
        rdata_d = rdata_q;

        if (state_q == IDLE) begin
            qcnt_d  = '0;
            phase_d = 2'd0;
            if (host.start) begin
                state_d = START;
                shift_d = {host.address, ~host.write};
                wdata_d = host.write_data;
                write_d = host.write;
                error_d = 1'b0;
                bit_d   = 3'd0;
            end
        end else begin
            qcnt_d = tick ? '0 : qcnt_q + 1'b1;
            if (tick) phase_d = phase_q + 2'd1;
            if (sample) ack_d = sda_in;
            if (sample && state_q == RDATA) shift_d = {shift_q[6:0], sda_in};
            if (slot_end) begin
                case (state_q)
                    START: state_d = ADDR;
                    ADDR, WDATA: begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = (state_q == ADDR) ? AACK : WACK;
                    end
                    AACK: begin
                        if (ack_q) begin
                            error_d = 1'b1;
                            state_d = STOP;
                        end else if (write_q) begin
                            shift_d = wdata_q;
                            state_d = WDATA;
                        end else begin
                            state_d = RDATA;
                        end
                    end
                    WACK: begin
                        if (ack_q) error_d = 1'b1;
                        state_d = STOP;
                    end
                    RDATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RNACK;
                    end
                    RNACK: begin
                        rdata_d = shift_q;
                        state_d = STOP;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // scl is high in phases 2-3 of a slot; START keeps it high for the whole slot
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            IDLE:  scl = 1'b1;
            START: sda_low = phase_q[1];
            ADDR, WDATA: begin
                scl     = phase_q[1];
                sda_low = ~shift_q[7];
            end
            STOP: begin
                scl     = phase_q[1];
                sda_low = (phase_q != 2'd3);
            end
            default: scl = phase_q[1];
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            phase_q <= 2'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            wdata_q <= 8'h00;
            write_q <= 1'b0;
            ack_q   <= 1'b1;
            error_q <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: two instances (QUARTER=4 and QUARTER=1), each with a bus-level
// SRAM-like slave answering addresses 7'h01 and 7'h50, checked against a transaction model.
module tb_i2c_master;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic       start_s [2];
    logic       write_s [2];
    logic [6:0] addr_s  [2];
    logic [7:0] wdata_s [2];
    logic [7:0] rdata_s [2];
    logic       ready_s [2];
    logic       error_s [2];
    logic       scl_s   [2];
    logic       sda_s   [2];
    int         mon_start [2];
    int         mon_stop  [2];
    logic [7:0] mon_abyte [2];
    logic [7:0] mon_wbyte [2];
    logic       mon_aack  [2];
    logic       mon_ack2  [2];

    for (genvar g = 0; g < 2; g++) begin : g_bus
        i2c_master_if hif ();
        wire        sda;
        logic       scl_w;
        logic       s_low = 1'b0;
        logic       scl_p, sda_p, s_sel, aack, ack2;
        logic [7:0] sh, abyte, wbyte;
        logic [7:0] smem [128];
        int         bitn;
        int         n_start = 0;
        int         n_stop = 0;

        pullup (sda);
        assign sda = s_low ? 1'b0 : 1'bz;

        i2c_master #(.QUARTER(g == 0 ? 4 : 1)) u_dut (
            .clock (clock),
            .reset (rst_n),
            .host  (hif),
            .scl   (scl_w),
            .sda   (sda)
        );

        assign hif.start      = start_s[g];
        assign hif.write      = write_s[g];
        assign hif.address    = addr_s[g];
        assign hif.write_data = wdata_s[g];
        assign rdata_s[g]     = hif.read_data;
        assign ready_s[g]     = hif.ready;
        assign error_s[g]     = hif.error;
        assign scl_s[g]       = scl_w;
        assign sda_s[g]       = sda;
        assign mon_start[g]   = n_start;
        assign mon_stop[g]    = n_stop;
        assign mon_abyte[g]   = abyte;
        assign mon_wbyte[g]   = wbyte;
        assign mon_aack[g]    = aack;
        assign mon_ack2[g]    = ack2;

        initial begin
            for (int k = 0; k < 128; k++) smem[k] = 8'h00;
            smem[7'h01] = 8'h3C;
            smem[7'h50] = 8'hC3;
        end

        // bus-level slave: decodes START/STOP, samples on scl rise, drives after scl fall
        always @(negedge clock or negedge rst_n) begin
            if (!rst_n) begin
                s_low <= 1'b0;
                scl_p <= 1'b1;
                sda_p <= 1'b1;
                s_sel <= 1'b0;
                bitn  <= -1;
            end else begin
                scl_p <= scl_w;
                sda_p <= sda;
                if (scl_w && scl_p && sda_p && !sda) begin
                    n_start <= n_start + 1;
                    bitn    <= 0;
                end else if (scl_w && scl_p && !sda_p && sda) begin
                    n_stop <= n_stop + 1;
                    bitn   <= -1;
                    s_low  <= 1'b0;
                end else if (scl_w && !scl_p && bitn >= 0) begin
                    sh <= {sh[6:0], sda};
                    if (bitn == 7)  abyte <= {sh[6:0], sda};
                    if (bitn == 8)  aack  <= sda;
                    if (bitn == 16) wbyte <= {sh[6:0], sda};
                    if (bitn == 17) ack2  <= sda;
                    bitn <= bitn + 1;
                end else if (!scl_w && scl_p && bitn >= 0) begin
                    s_low <= 1'b0;
                    if (bitn == 8) begin
                        s_sel <= (abyte[7:1] == 7'h01) || (abyte[7:1] == 7'h50);
                        s_low <= (abyte[7:1] == 7'h01) || (abyte[7:1] == 7'h50);
                    end
                    if (s_sel && abyte[0] && bitn >= 9 && bitn <= 16)
                        s_low <= ~smem[abyte[7:1]][16 - bitn];
                    if (s_sel && !abyte[0] && bitn == 17 && wbyte != 8'hFF) begin
                        s_low <= 1'b1;
                        smem[abyte[7:1]] <= wbyte;
                    end
                end
            end
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] ref_mem [2][128];
    logic [7:0] exp_rd  [2];

    typedef struct {
        bit         wr;
        logic [6:0] a;
        logic [7:0] d;
        bit         e_err;
        logic [7:0] e_rd;
        int         e_lat;
    } vec_t;
    vec_t tbl [8];

    function automatic int qv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit present(input logic [6:0] a);
        return (a == 7'h01) || (a == 7'h50);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic ref_txn(input int i, input bit wr, input logic [6:0] a, input logic [7:0] d,
                           output bit e_err, output logic [7:0] e_rd, output int e_lat);
        bit pres;
        pres  = present(a);
        e_err = !pres || (wr && d == 8'hFF);
        e_lat = (pres ? 80 : 44) * qv(i);
        if (pres && wr && d != 8'hFF) ref_mem[i][a] = d;
        if (pres && !wr) exp_rd[i] = ref_mem[i][a];
        e_rd = exp_rd[i];
    endtask

    task automatic do_txn(input int i, input bit wr, input logic [6:0] a, input logic [7:0] d,
                          input bit poke, input bit e_err, input logic [7:0] e_rd, input int e_lat);
        int s0, p0, lat;
        bit pres;
        pres = present(a);
        s0 = mon_start[i];
        p0 = mon_stop[i];
        @(posedge clock); #1;
        write_s[i] = wr;
        addr_s[i]  = a;
        wdata_s[i] = d;
        start_s[i] = 1'b1;
        @(posedge clock); #1;
        start_s[i] = 1'b0;
        chk("ready_low_after_accept", int'(ready_s[i]), 0);
        chk("error_cleared_on_accept", int'(error_s[i]), 0);
        lat = 0;
        while (!ready_s[i] && lat < 400) begin
            if (poke && lat >= 40 && lat < 46) begin
                start_s[i] = 1'b1;
                write_s[i] = ~wr;
                addr_s[i]  = 7'h22;
                wdata_s[i] = ~d;
            end else begin
                start_s[i] = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
        end
        start_s[i] = 1'b0;
        chk($sformatf("q%0d_latency", qv(i)), lat, e_lat);
        chk($sformatf("q%0d_error", qv(i)), int'(error_s[i]), int'(e_err));
        chk($sformatf("q%0d_read_data", qv(i)), int'(rdata_s[i]), int'(e_rd));
        chk("start_count", mon_start[i] - s0, 1);
        chk("stop_count", mon_stop[i] - p0, 1);
        chk("addr_byte", int'(mon_abyte[i]), int'({a, ~wr}));
        chk("addr_ack_bit", int'(mon_aack[i]), pres ? 0 : 1);
        if (pres) chk("ninth_bit_2", int'(mon_ack2[i]), (wr && d != 8'hFF) ? 0 : 1);
        if (pres && wr) chk("data_byte", int'(mon_wbyte[i]), int'(d));
    endtask

    bit         e_err;
    logic [7:0] e_rd;
    int         e_lat;

    initial begin
        tbl[0] = '{1'b0, 7'h01, 8'h00, 1'b0, 8'h3C, 320};
        tbl[1] = '{1'b1, 7'h01, 8'hA5, 1'b0, 8'h3C, 320};
        tbl[2] = '{1'b0, 7'h01, 8'h00, 1'b0, 8'hA5, 320};
        tbl[3] = '{1'b0, 7'h22, 8'h00, 1'b1, 8'hA5, 176};
        tbl[4] = '{1'b1, 7'h50, 8'hFF, 1'b1, 8'hA5, 320};
        tbl[5] = '{1'b1, 7'h22, 8'h12, 1'b1, 8'hA5, 176};
        tbl[6] = '{1'b1, 7'h50, 8'h5A, 1'b0, 8'hA5, 320};
        tbl[7] = '{1'b0, 7'h50, 8'h00, 1'b0, 8'h5A, 320};

        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            write_s[i] = 1'b0;
            addr_s[i]  = 7'h00;
            wdata_s[i] = 8'h00;
            exp_rd[i]  = 8'h00;
            for (int k = 0; k < 128; k++) ref_mem[i][k] = 8'h00;
            ref_mem[i][7'h01] = 8'h3C;
            ref_mem[i][7'h50] = 8'hC3;
        end

        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_scl", int'(scl_s[i]), 1);
            chk("reset_sda", int'(sda_s[i]), 1);
            chk("reset_ready", int'(ready_s[i]), 1);
            chk("reset_error", int'(error_s[i]), 0);
            chk("reset_read_data", int'(rdata_s[i]), 0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            ref_txn(0, tbl[v].wr, tbl[v].a, tbl[v].d, e_err, e_rd, e_lat);
            do_txn(0, tbl[v].wr, tbl[v].a, tbl[v].d, 1'b0, tbl[v].e_err, tbl[v].e_rd, tbl[v].e_lat);
        end

        // start pulsed mid-transfer must be ignored
        ref_txn(0, 1'b1, 7'h01, 8'h66, e_err, e_rd, e_lat);
        do_txn(0, 1'b1, 7'h01, 8'h66, 1'b1, e_err, e_rd, e_lat);

        // reset during WDATA bit 4 aborts immediately
        @(posedge clock); #1;
        write_s[0] = 1'b1;
        addr_s[0]  = 7'h01;
        wdata_s[0] = 8'h77;
        start_s[0] = 1'b1;
        @(posedge clock); #1;
        start_s[0] = 1'b0;
        repeat (227) @(posedge clock);
        #1;
        chk("mid_write_busy", int'(ready_s[0]), 0);
        chk("mid_write_scl_low", int'(scl_s[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_scl", int'(scl_s[0]), 1);
        chk("abort_sda", int'(sda_s[0]), 1);
        chk("abort_ready", int'(ready_s[0]), 1);
        chk("abort_read_data", int'(rdata_s[0]), 0);
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        ref_txn(0, 1'b1, 7'h01, 8'h77, e_err, e_rd, e_lat);
        do_txn(0, 1'b1, 7'h01, 8'h77, 1'b0, e_err, e_rd, e_lat);
        ref_txn(0, 1'b0, 7'h01, 8'h00, e_err, e_rd, e_lat);
        do_txn(0, 1'b0, 7'h01, 8'h00, 1'b0, e_err, e_rd, e_lat);
        chk("read_after_abort", int'(rdata_s[0]), 8'h77);

        // QUARTER=1 back-to-back write then read
        ref_txn(1, 1'b1, 7'h01, 8'hC7, e_err, e_rd, e_lat);
        do_txn(1, 1'b1, 7'h01, 8'hC7, 1'b0, e_err, e_rd, e_lat);
        ref_txn(1, 1'b0, 7'h01, 8'h00, e_err, e_rd, e_lat);
        do_txn(1, 1'b0, 7'h01, 8'h00, 1'b0, e_err, e_rd, e_lat);
        chk("q1_read_back", int'(rdata_s[1]), 8'hC7);

        for (int n = 0; n < 30; n++) begin
            int         i;
            bit         wr;
            logic [6:0] a;
            logic [7:0] d;
            i  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 7'h01;
                1:       a = 7'h50;
                2:       a = 7'h22;
                default: a = 7'($urandom);
            endcase
            d = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            ref_txn(i, wr, a, d, e_err, e_rd, e_lat);
            do_txn(i, wr, a, d, 1'b0, e_err, e_rd, e_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
